// File: rtl/ddr4_mon_pkg.sv
// Shared types and constants for the DDR4 command monitor: command codes,
// per-bank state encoding, error-bit positions and the RD/WR column mask.
package ddr4_mon_pkg;

    typedef enum logic [3:0] {
        CMD_NOP  = 4'd0,
        CMD_ACT  = 4'd1,
        CMD_MRS  = 4'd2,
        CMD_REF  = 4'd3,
        CMD_PRE  = 4'd4,
        CMD_PREA = 4'd5,
        CMD_RFU  = 4'd6,
        CMD_WR   = 4'd7,
        CMD_RD   = 4'd8,
        CMD_ZQC  = 4'd9
    } cmd_code_e;

    typedef enum logic [1:0] {
        BANK_IDLE        = 2'd0,
        BANK_ACTIVATING  = 2'd1,
        BANK_ACTIVE      = 2'd2,
        BANK_PRECHARGING = 2'd3
    } bank_state_e;

    localparam int ERR_RW_CLOSED = 0;
    localparam int ERR_RW_EARLY  = 1;
    localparam int ERR_ACT_OPEN  = 2;
    localparam int ERR_ACT_EARLY = 3;
    localparam int ERR_MULTI_CS  = 4;
    localparam int ERR_REF_OPEN  = 5;
    localparam int ERR_W         = 6;

    // Keeps A16..A14 and A10..A0; drops the row-only bits A13..A11.
    localparam logic [16:0] COL_MASK = 17'h1C7FF;

    function automatic cmd_code_e decode_cmd(input logic act_n, input logic [16:0] adr);
        cmd_code_e code;
        if (!act_n) begin
            code = CMD_ACT;
        end else begin
            case (adr[16:14])
                3'b000:  code = CMD_MRS;
                3'b001:  code = CMD_REF;
                3'b010:  code = adr[10] ? CMD_PREA : CMD_PRE;
                3'b011:  code = CMD_RFU;
                3'b100:  code = CMD_WR;
                3'b101:  code = CMD_RD;
                3'b110:  code = CMD_ZQC;
                default: code = CMD_NOP;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/ddr4_mon_bank.sv
// Timing tracker for one (rank, bank group, bank): state plus a shared
// tRCD/tRP countdown; flags illegal commands combinationally in the bus cycle.
module ddr4_mon_bank
    import ddr4_mon_pkg::*;
#(
    parameter int TRCD = 16,
    parameter int TRP  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       act,
    input  logic       pre,
    input  logic       rdwr,
    output logic       not_idle,
    output logic [3:0] err
);

    localparam int CNT_MAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TRCD_LOAD = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] TRP_LOAD  = CNT_W'(TRP - 1);

    bank_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);
    assign not_idle = (state != BANK_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BANK_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err       = '0;
        case (state)
            BANK_IDLE: begin
                if (act) begin
                    state_nxt = BANK_ACTIVATING;
                    cnt_nxt   = TRCD_LOAD;
                end else if (rdwr) begin
                    err[ERR_RW_CLOSED] = 1'b1;
                end
            end
            BANK_ACTIVATING: begin
                if (pre) begin
                    state_nxt = BANK_PRECHARGING;
                    cnt_nxt   = TRP_LOAD;
                end else begin
                    // Illegal ACT/RD/WR here must not disturb the tRCD countdown.
                    err[ERR_ACT_OPEN] = act;
                    err[ERR_RW_EARLY] = rdwr && !cnt_zero;
                    if (cnt_zero) state_nxt = BANK_ACTIVE;
                    else          cnt_nxt   = cnt - 1'b1;
                end
            end
            BANK_ACTIVE: begin
                if (pre) begin
                    state_nxt = BANK_PRECHARGING;
                    cnt_nxt   = TRP_LOAD;
                end else begin
                    err[ERR_ACT_OPEN] = act;
                end
            end
            BANK_PRECHARGING: begin
                if (act) begin
                    // An early ACT is flagged but the bank still opens.
                    err[ERR_ACT_EARLY] = !cnt_zero;
                    state_nxt          = BANK_ACTIVATING;
                    cnt_nxt            = TRCD_LOAD;
                end else begin
                    err[ERR_RW_CLOSED] = rdwr;
                    if (cnt_zero) state_nxt = BANK_IDLE;
                    else          cnt_nxt   = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = BANK_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/ddr4_cmd_monitor.sv
// Passive DDR4 command-bus monitor: decodes commands, tracks per-bank timing,
// and records protocol errors. Define DDR4_MON_STATS_EN for ACT/RD/WR counters.
module ddr4_cmd_monitor
    import ddr4_mon_pkg::*;
#(
    parameter int RANKS   = 1,
    parameter int BG_BITS = 1,
    parameter int TRCD    = 16,
    parameter int TRP     = 16
) (
    input  logic               c0_ddr4_ck_t,
    input  logic               sys_reset,
    input  logic               c0_ddr4_cke,
    input  logic [RANKS-1:0]   c0_ddr4_cs_n,
    input  logic               c0_ddr4_act_n,
    input  logic [16:0]        c0_ddr4_adr,
    input  logic [1:0]         c0_ddr4_ba,
    input  logic [BG_BITS-1:0] c0_ddr4_bg,
    input  logic               err_clr,
    output logic               cmd_valid,
    output logic [3:0]         cmd_code,
    output logic [1:0]         cmd_rank,
    output logic [16:0]        cmd_col,
    output logic [5:0]         err_sticky,
    output logic [15:0]        err_count
`ifdef DDR4_MON_STATS_EN
    ,
    output logic [31:0]        act_count,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
`endif
);

    localparam int NBG   = 1 << BG_BITS;
    localparam int BPR   = NBG * 4;
    localparam int NBANK = RANKS * BPR;

    logic [RANKS-1:0] cs_low;
    logic [2:0]       n_low;
    logic [1:0]       rank_p0;
    logic             single_p0, multi_p0, dec_valid_p0;
    cmd_code_e        dec_code_p0;
    logic             is_act, is_pre, is_prea, is_rdwr, is_ref;
    logic [NBANK-1:0] bank_busy;
    logic [3:0]       bank_err [NBANK];
    logic [3:0]       bank_err_any;
    logic [3:0]       rank_busy;
    logic [ERR_W-1:0] new_err_p0;
    logic             any_err_p0;

    // Stage p0: combinational decode of the current bus cycle
    assign cs_low = ~c0_ddr4_cs_n;

    always_comb begin
        n_low   = '0;
        rank_p0 = '0;
        for (int r = 0; r < RANKS; r++) begin
            n_low = n_low + {2'b00, cs_low[r]};
            if (cs_low[r]) rank_p0 = 2'(r);
        end
    end

    assign single_p0    = c0_ddr4_cke && (n_low == 3'd1);
    assign multi_p0     = c0_ddr4_cke && (n_low > 3'd1);
    assign dec_code_p0  = decode_cmd(c0_ddr4_act_n, c0_ddr4_adr);
    assign dec_valid_p0 = single_p0 && (dec_code_p0 != CMD_NOP);

    assign is_act  = dec_valid_p0 && (dec_code_p0 == CMD_ACT);
    assign is_pre  = dec_valid_p0 && (dec_code_p0 == CMD_PRE);
    assign is_prea = dec_valid_p0 && (dec_code_p0 == CMD_PREA);
    assign is_ref  = dec_valid_p0 && (dec_code_p0 == CMD_REF);
    assign is_rdwr = dec_valid_p0 && ((dec_code_p0 == CMD_RD) || (dec_code_p0 == CMD_WR));

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        localparam int R = i / BPR;
        localparam int G = (i / 4) % NBG;
        localparam int B = i % 4;
        logic hit_rank, hit_bank;

        assign hit_rank = (rank_p0 == 2'(R));
        assign hit_bank = hit_rank && (c0_ddr4_bg == BG_BITS'(G)) && (c0_ddr4_ba == 2'(B));

        ddr4_mon_bank #(
            .TRCD (TRCD),
            .TRP  (TRP)
        ) u_bank (
            .clk      (c0_ddr4_ck_t),
            .rst      (sys_reset),
            .act      (is_act && hit_bank),
            .pre      ((is_pre && hit_bank) || (is_prea && hit_rank)),
            .rdwr     (is_rdwr && hit_bank),
            .not_idle (bank_busy[i]),
            .err      (bank_err[i])
        );
    end

    always_comb begin
        bank_err_any = '0;
        for (int i = 0; i < NBANK; i++) bank_err_any = bank_err_any | bank_err[i];
    end

    always_comb begin
        rank_busy = '0;
        for (int r = 0; r < RANKS; r++) rank_busy[r] = |bank_busy[r*BPR +: BPR];
    end

    always_comb begin
        new_err_p0               = '0;
        new_err_p0[3:0]          = bank_err_any;
        new_err_p0[ERR_MULTI_CS] = multi_p0;
        new_err_p0[ERR_REF_OPEN] = is_ref && rank_busy[rank_p0];
    end

    assign any_err_p0 = |new_err_p0;

    // Stage p1: registered command report and error bookkeeping
    always_ff @(posedge c0_ddr4_ck_t) begin
        if (sys_reset) begin
            cmd_valid  <= 1'b0;
            cmd_code   <= '0;
            cmd_rank   <= '0;
            cmd_col    <= '0;
            err_sticky <= '0;
            err_count  <= '0;
        end else begin
            cmd_valid  <= dec_valid_p0;
            cmd_code   <= dec_valid_p0 ? dec_code_p0 : CMD_NOP;
            cmd_rank   <= dec_valid_p0 ? rank_p0 : 2'd0;
            cmd_col    <= !dec_valid_p0 ? 17'd0 :
                          is_rdwr ? (c0_ddr4_adr & COL_MASK) : c0_ddr4_adr;
            err_sticky <= (err_clr ? '0 : err_sticky) | new_err_p0;
            if (err_clr)
                err_count <= {15'd0, any_err_p0};
            else if (any_err_p0 && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
        end
    end

`ifdef DDR4_MON_STATS_EN
    always_ff @(posedge c0_ddr4_ck_t) begin
        if (sys_reset) begin
            act_count <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (is_act && (act_count != '1)) act_count <= act_count + 32'd1;
            if (dec_valid_p0 && (dec_code_p0 == CMD_RD) && (rd_count != '1))
                rd_count <= rd_count + 32'd1;
            if (dec_valid_p0 && (dec_code_p0 == CMD_WR) && (wr_count != '1))
                wr_count <= wr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr4_cmd_monitor.sv
// Directed scoreboard bench for ddr4_cmd_monitor (RANKS=2, BG_BITS=1, TRCD=TRP=16).
module tb_ddr4_cmd_monitor;
    import ddr4_mon_pkg::*;

    localparam logic [16:0] NOP_ADR = 17'h1C000;

    logic        clk = 1'b0;
    logic        sys_reset = 1'b1;
    logic        cke = 1'b0;
    logic [1:0]  cs_n = 2'b11;
    logic        act_n = 1'b1;
    logic [16:0] adr = NOP_ADR;
    logic [1:0]  ba = 2'd0;
    logic [0:0]  bg = 1'b0;
    logic        err_clr = 1'b0;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic [1:0]  cmd_rank;
    logic [16:0] cmd_col;
    logic [5:0]  err_sticky;
    logic [15:0] err_count;
`ifdef DDR4_MON_STATS_EN
    logic [31:0] act_count, rd_count, wr_count;
`endif

    always #5 clk = ~clk;

    ddr4_cmd_monitor #(.RANKS(2), .BG_BITS(1), .TRCD(16), .TRP(16)) dut (
        .c0_ddr4_ck_t  (clk),
        .sys_reset     (sys_reset),
        .c0_ddr4_cke   (cke),
        .c0_ddr4_cs_n  (cs_n),
        .c0_ddr4_act_n (act_n),
        .c0_ddr4_adr   (adr),
        .c0_ddr4_ba    (ba),
        .c0_ddr4_bg    (bg),
        .err_clr       (err_clr),
        .cmd_valid     (cmd_valid),
        .cmd_code      (cmd_code),
        .cmd_rank      (cmd_rank),
        .cmd_col       (cmd_col),
        .err_sticky    (err_sticky),
        .err_count     (err_count)
`ifdef DDR4_MON_STATS_EN
        ,
        .act_count     (act_count),
        .rd_count      (rd_count),
        .wr_count      (wr_count)
`endif
    );

    typedef struct {
        string       name;
        int          due;
        logic        full;
        logic        valid;
        logic [3:0]  code;
        logic [1:0]  rank;
        logic [16:0] col;
        logic [5:0]  sticky;
        logic [15:0] count;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [5:0]  m_sticky = '0;
    logic [15:0] m_count = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop the entry due this cycle and compare against the DUT
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            ok = (e.due == cyc) && (cmd_valid === e.valid) &&
                 (err_sticky === e.sticky) && (err_count === e.count);
            if (e.full)
                ok = ok && (cmd_code === e.code) && (cmd_rank === e.rank) && (cmd_col === e.col);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL %s @%0d: got v=%b code=%0d rank=%0d col=%h sticky=%b count=%h, want v=%b code=%0d rank=%0d col=%h sticky=%b count=%h (full=%b due=%0d)",
                         e.name, cyc, cmd_valid, cmd_code, cmd_rank, cmd_col, err_sticky, err_count,
                         e.valid, e.code, e.rank, e.col, e.sticky, e.count, e.full, e.due);
            end
        end else if (cmd_valid === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid @%0d: got cmd_valid=1 code=%0d, want no command", cyc, cmd_code);
        end
    end

    function automatic logic [1:0] cs_of(input int r);
        logic [1:0] v;
        v    = 2'b11;
        v[r] = 1'b0;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic k, input logic [1:0] cs, input logic an,
                         input logic [16:0] a, input logic g, input logic [1:0] b, input logic clr);
        @(posedge clk);
        #1;
        sys_reset = rst;
        cke       = k;
        cs_n      = cs;
        act_n     = an;
        adr       = a;
        bg        = g;
        ba        = b;
        err_clr   = clr;
    endtask

    task automatic expect_out(input string n, input logic full, input logic valid, input logic [3:0] code,
                              input logic [1:0] rank, input logic [16:0] col, input logic [5:0] emask,
                              input logic clr);
        exp_t e;
        if (clr) begin
            m_sticky = emask;
            m_count  = (emask != 0) ? 16'd1 : 16'd0;
        end else if (emask != 0) begin
            m_sticky = m_sticky | emask;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end
        e.name = n; e.due = cyc + 1; e.full = full; e.valid = valid; e.code = code;
        e.rank = rank; e.col = col; e.sticky = m_sticky; e.count = m_count;
        q.push_back(e);
    endtask

    task automatic cmd(input string n, input int r, input logic g, input logic [1:0] b, input logic an,
                       input logic [16:0] a, input logic [3:0] code, input logic [16:0] col,
                       input logic [5:0] emask);
        drive(1'b0, 1'b1, cs_of(r), an, a, g, b, 1'b0);
        expect_out(n, 1'b1, 1'b1, code, 2'(r), col, emask, 1'b0);
    endtask

    task automatic idle(input int n, input logic clr);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 2'b11, 1'b1, NOP_ADR, 1'b0, 2'd0, clr);
            expect_out("idle", 1'b0, 1'b0, 4'd0, 2'd0, 17'd0, 6'd0, clr);
        end
    endtask

    task automatic do_reset(input int n);
        m_sticky = '0;
        m_count  = '0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, 2'b11, 1'b1, NOP_ADR, 1'b0, 2'd0, 1'b0);
            expect_out("reset", 1'b1, 1'b0, 4'd0, 2'd0, 17'd0, 6'd0, 1'b0);
        end
    endtask

    initial begin
        do_reset(3);
        idle(2, 1'b0);

        // Legal ACT -> RD at exactly tRCD, then RD/WR while open, then PRE
        cmd("act_a", 0, 1'b0, 2'd1, 1'b0, 17'h00123, CMD_ACT, 17'h00123, 6'h00);
        idle(15, 1'b0);
        cmd("rd_a_trcd", 0, 1'b0, 2'd1, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h00);
        cmd("rd_a_open", 0, 1'b0, 2'd1, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h00);
        cmd("wr_a_mask", 0, 1'b0, 2'd1, 1'b1, 17'h10ABC, CMD_WR, 17'h102BC, 6'h00);
        cmd("pre_a", 0, 1'b0, 2'd1, 1'b1, 17'h08000, CMD_PRE, 17'h08000, 6'h00);

        // Early RD while activating; the countdown must still finish on time
        cmd("act_b", 0, 1'b1, 2'd2, 1'b0, 17'h00456, CMD_ACT, 17'h00456, 6'h00);
        idle(4, 1'b0);
        cmd("rd_b_early5", 0, 1'b1, 2'd2, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h02);
        idle(4, 1'b0);
        cmd("rd_b_early10", 0, 1'b1, 2'd2, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h02);
        idle(5, 1'b0);
        cmd("rd_b_trcd", 0, 1'b1, 2'd2, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h00);
        cmd("rd_b_open", 0, 1'b1, 2'd2, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h00);

        // PREA then early ACT, then the remaining error classes
        cmd("prea_r0", 0, 1'b0, 2'd0, 1'b1, 17'h08400, CMD_PREA, 17'h08400, 6'h00);
        idle(2, 1'b0);
        cmd("act_b_early", 0, 1'b1, 2'd2, 1'b0, 17'h00456, CMD_ACT, 17'h00456, 6'h08);
        cmd("rd_b_activating", 0, 1'b1, 2'd2, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h02);
        cmd("act_b_open", 0, 1'b1, 2'd2, 1'b0, 17'h00456, CMD_ACT, 17'h00456, 6'h04);
        cmd("rd_idle_r1", 1, 1'b0, 2'd0, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h01);
        cmd("ref_r0_busy", 0, 1'b0, 2'd0, 1'b1, 17'h04000, CMD_REF, 17'h04000, 6'h20);
        cmd("ref_r1_idle", 1, 1'b0, 2'd0, 1'b1, 17'h04000, CMD_REF, 17'h04000, 6'h00);
        cmd("mrs_r1", 1, 1'b1, 2'd3, 1'b1, 17'h00005, CMD_MRS, 17'h00005, 6'h00);
        cmd("zqc_r0", 0, 1'b0, 2'd0, 1'b1, 17'h18400, CMD_ZQC, 17'h18400, 6'h00);
        idle(1, 1'b1);
        idle(1, 1'b0);

        // Multi-CS and CKE-low cycles must not touch bank g0/b3
        drive(1'b0, 1'b1, 2'b00, 1'b0, 17'h00999, 1'b0, 2'd3, 1'b0);
        expect_out("multi_cs", 1'b0, 1'b0, 4'd0, 2'd0, 17'd0, 6'h10, 1'b0);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 17'h00999, 1'b0, 2'd3, 1'b0);
        expect_out("cke_low", 1'b0, 1'b0, 4'd0, 2'd0, 17'd0, 6'h00, 1'b0);
        cmd("rd_r0_g0b3_idle", 0, 1'b0, 2'd3, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h01);
        cmd("rd_r1_g0b3_idle", 1, 1'b0, 2'd3, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h01);

        // Saturate the error counter, then clear with a concurrent error
        for (int i = 0; i < 70000; i++)
            drive(1'b0, 1'b1, 2'b00, 1'b1, NOP_ADR, 1'b0, 2'd0, 1'b0);
        m_sticky = m_sticky | 6'h10;
        m_count  = 16'hFFFF;
        idle(1, 1'b0);
        drive(1'b0, 1'b1, 2'b00, 1'b1, NOP_ADR, 1'b0, 2'd0, 1'b1);
        expect_out("clr_with_err", 1'b0, 1'b0, 4'd0, 2'd0, 17'd0, 6'h10, 1'b1);
        idle(1, 1'b0);

        // Reset in the middle of tRCD abandons the countdown
        cmd("act_f", 1, 1'b0, 2'd0, 1'b0, 17'h00777, CMD_ACT, 17'h00777, 6'h00);
        idle(3, 1'b0);
        do_reset(2);
`ifdef DDR4_MON_STATS_EN
        @(negedge clk);
        tests++;
        if (act_count !== 32'd0) begin
            fails++;
            $display("FAIL act_count_after_reset: got %0d, want 0", act_count);
        end
`endif
        cmd("rd_f_after_reset", 1, 1'b0, 2'd0, 1'b1, 17'h17FFF, CMD_RD, 17'h147FF, 6'h01);
        idle(3, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
